id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection.
//  Captures decoded operands/control from ID each cycle; drives EX stage and the forwarding unit (RN1/RN2/MW).
//  Inserts one bubble and stalls PC + IF/ID on a load-use dependency; supports branch flush and downstream hold.
// PARAMETERS
//  DATA_W   32  operand / immediate / PC width
//  REG_AW   4   register-number width (reg 0 = hardwired zero)
//  ALUOP_W  4   ALU opcode width
//  CNT_W    16  stall-cycle counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        async active-low reset
//  id_valid     in   1        ID holds a real instruction
//  id_rn1       in   REG_AW   source reg 1
//  id_rn2       in   REG_AW   source reg 2
//  id_uses_rn2  in   1        instruction reads rn2 (R-type / store)
//  id_wn        in   REG_AW   destination reg
//  id_rd1       in   DATA_W   regfile read data 1
//  id_rd2       in   DATA_W   regfile read data 2
//  id_imm       in   DATA_W   sign-extended immediate
//  id_pc        in   DATA_W   instruction PC
//  id_aluop     in   ALUOP_W  ALU opcode
//  id_mr, id_mw, id_enrw, id_alusrc, id_mem2reg  in 1 each  control bits
//  flush        in   1        branch taken in EX: squash ID/EX
//  ex_hold      in   1        downstream stall: freeze ID/EX
//  wb_enrw      in   1        WB-stage write enable
//  wb_wn        in   REG_AW   WB-stage dest reg
//  wb_data      in   DATA_W   WB-stage write data
//  ex_valid     out  1        ID/EX holds real instruction
//  ID_EX_RN1, ID_EX_RN2, ID_EX_WN  out REG_AW  registered reg numbers
//  ID_EX_RD1, ID_EX_RD2, ID_EX_IMM, ID_EX_PC  out DATA_W  registered data
//  ID_EX_ALUOP  out  ALUOP_W
//  ID_EX_MR, ID_EX_MW, ID_EX_EnRW, ID_EX_ALUSRC, ID_EX_M2R  out 1 each
//  hazard_stall out  1        combinational: hold PC and IF/ID this cycle
//  stall_cnt    out  CNT_W    saturating count of load-use bubbles
// BEHAVIOUR
//  - Reset (rst_n=0, async): every registered output = 0; stall_cnt = 0.
//  - lu_hit = id_valid & ID_EX_MR & ex_valid & ID_EX_WN!=0 &
//    (ID_EX_WN==id_rn1 | (id_uses_rn2 & ID_EX_WN==id_rn2)).
//  - hazard_stall = lu_hit & ~flush | ex_hold. Combinational, no latency.
//  - Per rising edge, priority highest first:
//    1 ex_hold: all ID/EX regs keep value; stall_cnt unchanged.
//    2 flush:   bubble (below); flush beats lu_hit; no stall_cnt increment.
//    3 lu_hit:  bubble; stall_cnt += 1, saturating at all-ones.
//    4 else:    load all id_* fields; ex_valid = id_valid.
//  - Bubble: ex_valid, MR, MW, EnRW, ALUSRC, M2R = 0; RN1, RN2, WN = 0;
//    ALUOP = 0; RD1, RD2, IMM, PC = 0. Zeroed RN/WN keep forwarding inactive.
//  - Latency: ID input to ID/EX output = 1 cycle; a load-use costs exactly 1 bubble:
//    the next cycle ID/EX holds no load, so lu_hit clears and the held ID instr advances.
//  - id_valid=0 under normal load: captured as bubble, control bits forced 0.
//  - Back-to-back load-use chains: each dependent pair costs 1 bubble, counted each time.
// CONFIGURATION
//  WB_BYPASS_EN defined: on normal load, if wb_enrw & wb_wn!=0 & wb_wn==id_rn1,
//    ID_EX_RD1 <= wb_data (likewise rn2 -> RD2); covers regfile write/read same cycle.
//  Undefined: RD1/RD2 always from id_rd1/id_rd2; wb_* ports present but ignored.
// TESTING
//  1 Reset mid-run: rst_n low async, while ID/EX holds a load -> all outputs 0 at once,
//    stall_cnt=0, hazard_stall=0.
//  2 Load-use: LW r3 in ID/EX, ADD r4,r3,r1 in ID -> hazard_stall=1 one cycle,
//    next edge ID/EX bubble (EnRW=0, WN=0), following edge ADD captured, stall_cnt=1.
//  3 rn2 gating: LW r5 in ID/EX, ADDI r6,r2 with id_uses_rn2=0, id_rn2=5 -> no stall.
//  4 Flush vs lu_hit same cycle: both asserted -> bubble, hazard_stall=0, stall_cnt unchanged.
//  5 ex_hold 3 cycles with LW r3 in ID/EX -> outputs frozen, hazard_stall=1 throughout,
//    stall_cnt unchanged; load-use bubble on release.
//  6 WB_BYPASS_EN: wb_enrw=1, wb_wn=7, wb_data=0xDEADBEEF, id_rn1=7, id_rd1=0 ->
//    ID_EX_RD1=0xDEADBEEF; without macro ID_EX_RD1=0. wb_wn=0 -> no bypass.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection, branch flush and downstream hold.
// Optional macro WB_BYPASS_EN: forward the WB-stage write data into RD1/RD2 on capture.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rn1,
  input  logic [REG_AW-1:0]  id_rn2,
  input  logic               id_uses_rn2,
  input  logic [REG_AW-1:0]  id_wn,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_mr,
  input  logic               id_mw,
  input  logic               id_enrw,
  input  logic               id_alusrc,
  input  logic               id_mem2reg,
  input  logic               flush,
  input  logic               ex_hold,
  input  logic               wb_enrw,
  input  logic [REG_AW-1:0]  wb_wn,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ID_EX_RN1,
  output logic [REG_AW-1:0]  ID_EX_RN2,
  output logic [REG_AW-1:0]  ID_EX_WN,
  output logic [DATA_W-1:0]  ID_EX_RD1,
  output logic [DATA_W-1:0]  ID_EX_RD2,
  output logic [DATA_W-1:0]  ID_EX_IMM,
  output logic [DATA_W-1:0]  ID_EX_PC,
  output logic [ALUOP_W-1:0] ID_EX_ALUOP,
  output logic               ID_EX_MR,
  output logic               ID_EX_MW,
  output logic               ID_EX_EnRW,
  output logic               ID_EX_ALUSRC,
  output logic               ID_EX_M2R,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rn1;
    logic [REG_AW-1:0]  rn2;
    logic [REG_AW-1:0]  wn;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
    logic [ALUOP_W-1:0] aluop;
    logic               mr;
    logic               mw;
    logic               enrw;
    logic               alusrc;
    logic               m2r;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rn1_dep_c, rn2_dep_c, lu_hit_c;
  logic [DATA_W-1:0] rd1_sel_c, rd2_sel_c;

  // Load in EX whose destination is read by the instruction sitting in ID.
  assign rn1_dep_c = (stage_q.wn == id_rn1);
  assign rn2_dep_c = id_uses_rn2 && (stage_q.wn == id_rn2);
  assign lu_hit_c  = id_valid && stage_q.mr && stage_q.valid && (stage_q.wn != '0)
                     && (rn1_dep_c || rn2_dep_c);

  assign hazard_stall = (lu_hit_c && !flush) || ex_hold;

`ifdef WB_BYPASS_EN
  // Same-cycle regfile write/read: take the WB value instead of the stale read.
  always_comb begin
    rd1_sel_c = id_rd1;
    rd2_sel_c = id_rd2;
    if (wb_enrw && (wb_wn != '0) && (wb_wn == id_rn1)) rd1_sel_c = wb_data;
    if (wb_enrw && (wb_wn != '0) && (wb_wn == id_rn2)) rd2_sel_c = wb_data;
  end
`else
  logic wb_unused_c;
  assign wb_unused_c = ^{wb_enrw, wb_wn, wb_data};
  assign rd1_sel_c   = id_rd1;
  assign rd2_sel_c   = id_rd2;
`endif

  // Next-state selection: hold > flush > load-use bubble > normal capture.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (ex_hold) begin
      stage_d = stage_q;
    end else if (flush) begin
      stage_d = '0;
    end else if (lu_hit_c) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (id_valid) begin
      stage_d.valid  = 1'b1;
      stage_d.rn1    = id_rn1;
      stage_d.rn2    = id_rn2;
      stage_d.wn     = id_wn;
      stage_d.rd1    = rd1_sel_c;
      stage_d.rd2    = rd2_sel_c;
      stage_d.imm    = id_imm;
      stage_d.pc     = id_pc;
      stage_d.aluop  = id_aluop;
      stage_d.mr     = id_mr;
      stage_d.mw     = id_mw;
      stage_d.enrw   = id_enrw;
      stage_d.alusrc = id_alusrc;
      stage_d.m2r    = id_mem2reg;
    end else begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ID_EX_RN1    = stage_q.rn1;
  assign ID_EX_RN2    = stage_q.rn2;
  assign ID_EX_WN     = stage_q.wn;
  assign ID_EX_RD1    = stage_q.rd1;
  assign ID_EX_RD2    = stage_q.rd2;
  assign ID_EX_IMM    = stage_q.imm;
  assign ID_EX_PC     = stage_q.pc;
  assign ID_EX_ALUOP  = stage_q.aluop;
  assign ID_EX_MR     = stage_q.mr;
  assign ID_EX_MW     = stage_q.mw;
  assign ID_EX_EnRW   = stage_q.enrw;
  assign ID_EX_ALUSRC = stage_q.alusrc;
  assign ID_EX_M2R    = stage_q.m2r;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: cycle model of the ID/EX register plus directed load-use scenarios.
module tb_id_ex_stage_reg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_uses_rn2 = 0, id_mr = 0, id_mw = 0, id_enrw = 0, id_alusrc = 0, id_mem2reg = 0;
  logic [REG_AW-1:0] id_rn1 = 0, id_rn2 = 0, id_wn = 0, wb_wn = 0;
  logic [DATA_W-1:0] id_rd1 = 0, id_rd2 = 0, id_imm = 0, id_pc = 0, wb_data = 0;
  logic [ALUOP_W-1:0] id_aluop = 0;
  logic flush = 0, ex_hold = 0, wb_enrw = 0;

  logic ex_valid, mr, mw, enrw, alusrc, m2r, hazard_stall;
  logic [REG_AW-1:0] rn1, rn2, wn;
  logic [DATA_W-1:0] rd1, rd2, imm, pc;
  logic [ALUOP_W-1:0] aluop;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn1(id_rn1), .id_rn2(id_rn2),
    .id_uses_rn2(id_uses_rn2), .id_wn(id_wn), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_pc(id_pc), .id_aluop(id_aluop), .id_mr(id_mr), .id_mw(id_mw), .id_enrw(id_enrw),
    .id_alusrc(id_alusrc), .id_mem2reg(id_mem2reg), .flush(flush), .ex_hold(ex_hold),
    .wb_enrw(wb_enrw), .wb_wn(wb_wn), .wb_data(wb_data), .ex_valid(ex_valid),
    .ID_EX_RN1(rn1), .ID_EX_RN2(rn2), .ID_EX_WN(wn), .ID_EX_RD1(rd1), .ID_EX_RD2(rd2),
    .ID_EX_IMM(imm), .ID_EX_PC(pc), .ID_EX_ALUOP(aluop), .ID_EX_MR(mr), .ID_EX_MW(mw),
    .ID_EX_EnRW(enrw), .ID_EX_ALUSRC(alusrc), .ID_EX_M2R(m2r), .hazard_stall(hazard_stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently in EX, as a flat record, plus the bubble tally.
  logic m_valid, m_mr, m_mw, m_enrw, m_alusrc, m_m2r;
  logic [REG_AW-1:0] m_rn1, m_rn2, m_wn;
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [ALUOP_W-1:0] m_aluop;
  int m_bubbles;

  function automatic logic model_lu();
    return id_valid && m_valid && m_mr && (m_wn != 0) &&
           ((m_wn == id_rn1) || (id_uses_rn2 && (m_wn == id_rn2)));
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [REG_AW-1:0] rn, input logic [DATA_W-1:0] rf);
`ifdef WB_BYPASS_EN
    if (wb_enrw && wb_wn != 0 && wb_wn == rn) return wb_data;
`endif
    return rf;
  endfunction

  task automatic model_clear();
    {m_valid, m_mr, m_mw, m_enrw, m_alusrc, m_m2r} = '0;
    {m_rn1, m_rn2, m_wn, m_rd1, m_rd2, m_imm, m_pc, m_aluop} = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      m_bubbles = 0;
    end else if (ex_hold) begin
      // frozen
    end else if (flush || !id_valid) begin
      model_clear();
    end else if (model_lu()) begin
      model_clear();
      m_bubbles = m_bubbles + 1;
    end else begin
      m_valid = 1; m_rn1 = id_rn1; m_rn2 = id_rn2; m_wn = id_wn;
      m_rd1 = pick(id_rn1, id_rd1); m_rd2 = pick(id_rn2, id_rd2);
      m_imm = id_imm; m_pc = id_pc; m_aluop = id_aluop;
      m_mr = id_mr; m_mw = id_mw; m_enrw = id_enrw; m_alusrc = id_alusrc; m_m2r = id_mem2reg;
    end
  end

  // Compare process: every falling edge once out of the initial reset.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", {ex_valid, mr, mw, enrw, alusrc, m2r}, {m_valid, m_mr, m_mw, m_enrw, m_alusrc, m_m2r});
      chk("regnums", {rn1, rn2, wn, aluop}, {m_rn1, m_rn2, m_wn, m_aluop});
      chk("data", {rd1, rd2, imm, pc}, {m_rd1, m_rd2, m_imm, m_pc});
      chk("stall_cnt", stall_cnt, (m_bubbles > 7) ? 7 : m_bubbles);
      chk("hazard_stall", hazard_stall, (model_lu() && !flush) || ex_hold);
    end
  end

  task automatic drive(input logic v, input logic [REG_AW-1:0] w, input logic [REG_AW-1:0] s1,
                       input logic [REG_AW-1:0] s2, input logic u2, input logic load,
                       input logic [DATA_W-1:0] p);
    id_valid = v; id_wn = w; id_rn1 = s1; id_rn2 = s2; id_uses_rn2 = u2;
    id_mr = load; id_mem2reg = load; id_enrw = v; id_alusrc = load | ~u2; id_mw = 0;
    id_rd1 = 32'h1000 + 32'(s1); id_rd2 = 32'h2000 + 32'(s2); id_imm = p ^ 32'h55; id_pc = p;
    id_aluop = load ? 4'h0 : 4'h2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk); #1;
    chk_en = 1;
    chk("reset_valid", ex_valid, 0);
    chk("reset_cnt", stall_cnt, 0);

    // Load-use: LW r3 then ADD r4,r3,r1
    drive(1, 3, 0, 0, 0, 1, 32'h100); tick();
    chk("lw_wn", wn, 3);
    drive(1, 4, 3, 1, 1, 0, 32'h104); #1;
    chk("lu_stall", hazard_stall, 1);
    tick();
    chk("lu_bubble_enrw", enrw, 0);
    chk("lu_bubble_wn", wn, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_stall_clear", hazard_stall, 0);
    tick();
    chk("add_wn", wn, 4);
    chk("add_pc", pc, 32'h104);
    chk("add_cnt", stall_cnt, 1);

    // rn2 gating: ADDI r6,r2 with rn2 field = 5 but not read
    drive(1, 5, 0, 0, 0, 1, 32'h200); tick();
    drive(1, 6, 2, 5, 0, 0, 32'h204); #1;
    chk("rn2_gate_stall", hazard_stall, 0);
    tick();
    chk("rn2_gate_wn", wn, 6);

    // rn2 dependency does stall when read
    drive(1, 5, 0, 0, 0, 1, 32'h210); tick();
    drive(1, 7, 2, 5, 1, 0, 32'h214); #1;
    chk("rn2_dep_stall", hazard_stall, 1);
    tick(); tick();
    chk("rn2_dep_cnt", stall_cnt, 2);

    // Flush and lu_hit together
    drive(1, 3, 0, 0, 0, 1, 32'h300); tick();
    drive(1, 4, 3, 1, 1, 0, 32'h304); flush = 1; #1;
    chk("flush_stall", hazard_stall, 0);
    tick(); flush = 0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_cnt", stall_cnt, 2);
    tick();

    // ex_hold for 3 cycles with LW r3 in EX
    drive(1, 3, 0, 0, 0, 1, 32'h400); tick();
    drive(1, 4, 3, 1, 1, 0, 32'h404); ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_wn", wn, 3);
      chk("hold_mr", mr, 1);
      chk("hold_stall", hazard_stall, 1);
      chk("hold_cnt", stall_cnt, 2);
    end
    ex_hold = 0; tick();
    chk("hold_release_bubble", ex_valid, 0);
    chk("hold_release_cnt", stall_cnt, 3);
    tick();
    chk("hold_add_wn", wn, 4);

    // idle ID captured as bubble
    drive(0, 9, 9, 9, 1, 1, 32'h500); tick();
    chk("idle_valid", ex_valid, 0);
    chk("idle_mr", mr, 0);

    // WB bypass
    drive(1, 8, 7, 0, 0, 0, 32'h600); id_rd1 = 0;
    wb_enrw = 1; wb_wn = 7; wb_data = 32'hDEADBEEF; tick();
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", rd1, 32'hDEADBEEF);
`else
    chk("bypass_rd1", rd1, 0);
`endif
    drive(1, 8, 0, 0, 0, 0, 32'h604); id_rd1 = 32'h11; wb_wn = 0; tick();
    chk("bypass_r0", rd1, 32'h11);
    wb_enrw = 0;

    // Reset mid-run with LW in EX and a dependent in ID
    drive(1, 3, 0, 0, 0, 1, 32'h700); tick();
    drive(1, 4, 3, 1, 1, 0, 32'h704); #1;
    rst_n = 0; #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_all", {mr, enrw, m2r, wn, rd1, rd2, imm, pc}, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", hazard_stall, 0);
    @(negedge clk); #2 rst_n = 1;

    // Saturation: nine load-use pairs on a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      drive(1, 2, 0, 0, 0, 1, 32'h800 + 32'(i * 8)); tick();
      drive(1, 5, 2, 0, 0, 0, 32'h804 + 32'(i * 8)); tick(); tick();
    end
    chk("sat_cnt", stall_cnt, 7);
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
